// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory arbiter slice: arbiter state
// encoding, requester port identifiers and the byte-enable width.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_HOLDOFF = 2'd2
  } arb_state_e;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int BE_W = 4;

endpackage

// File: rtl/mem_lock_timer.sv
// Counts the cycles the debug port has held its exclusive lock.
// clr restarts the count on lock entry, en advances it while locked, and
// expire flags the last cycle the lock may still be held. The count
// saturates rather than wrapping so a missed exit can never re-arm it.
module mem_lock_timer #(
  parameter int LOCK_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  logic [CNT_W-1:0] lock_cnt;

  // Saturating lock-age counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      lock_cnt <= {CNT_W{1'b0}};
    end else if (en && (lock_cnt != CNT_LAST)) begin
      lock_cnt <= lock_cnt + CNT_W'(1);
    end
  end

  assign expire = (lock_cnt == CNT_LAST);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core load/store unit (C)
// and the debug/loader port (D). Grants and the memory command are
// combinational in the request cycle; read data returns one cycle later
// to whichever port owned the read. D may take a bounded exclusive lock.
// Optional feature: define ARB_RR_EN for round-robin contention handling
// (default build uses fixed priority with the core winning).
module dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [BE_W-1:0]   c_be,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              core_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              lock_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state;
  logic       owner_q;
  logic       rd_pend_q;
  logic       lock_enter;
  logic       lock_expire;
  logic       lock_timeout;
  logic       rd_grant;
`ifdef ARB_RR_EN
  logic       last_q;
`endif

  // Grant decision for the current cycle
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
    end else begin
      case (state)
        ST_LOCKED: begin
          c_gnt = 1'b0;
          d_gnt = d_req;
        end
        ST_IDLE, ST_HOLDOFF: begin
`ifdef ARB_RR_EN
          if (c_req && d_req) begin
            if (last_q == PORT_D) begin
              c_gnt = 1'b1;
            end else begin
              d_gnt = 1'b1;
            end
          end else begin
            c_gnt = c_req;
            d_gnt = d_req;
          end
`else
          c_gnt = c_req;
          d_gnt = d_req & ~c_req;
`endif
        end
        default: begin
          c_gnt = 1'b0;
          d_gnt = 1'b0;
        end
      endcase
    end
  end

  // Route the winner's command onto the memory port
  always_comb begin
    if (d_gnt) begin
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (c_gnt) begin
      mem_we    = c_we;
      mem_be    = c_be;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_be    = {BE_W{1'b0}};
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  assign mem_en       = c_gnt | d_gnt;
  assign core_stall   = c_req & ~c_gnt;
  assign lock_enter   = (state == ST_IDLE) & d_gnt & d_lock;
  assign lock_timeout = (state == ST_LOCKED) & d_lock & lock_expire;
  assign rd_grant     = (c_gnt & ~c_we) | (d_gnt & ~d_we);

  mem_lock_timer #(
    .LOCK_MAX (LOCK_MAX)
  ) u_lock_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (lock_enter),
    .en     (state == ST_LOCKED),
    .expire (lock_expire)
  );

  // Arbiter state, lock timeout pulse and pending-read ownership
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lock_err  <= 1'b0;
      rd_pend_q <= 1'b0;
      owner_q   <= PORT_C;
    end else begin
      lock_err  <= lock_timeout;
      rd_pend_q <= rd_grant;
      if (c_gnt || d_gnt) begin
        owner_q <= d_gnt ? PORT_D : PORT_C;
      end
      case (state)
        ST_IDLE:    state <= lock_enter ? ST_LOCKED : ST_IDLE;
        ST_LOCKED: begin
          // Releasing the lock takes precedence over a coincident timeout
          if (!d_lock) begin
            state <= ST_IDLE;
          end else if (lock_expire) begin
            state <= ST_HOLDOFF;
          end else begin
            state <= ST_LOCKED;
          end
        end
        ST_HOLDOFF: state <= d_lock ? ST_HOLDOFF : ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_RR_EN
  // Remember the most recent winner for round-robin contention
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= PORT_D;
    end else if (c_gnt || d_gnt) begin
      last_q <= d_gnt ? PORT_D : PORT_C;
    end
  end
`endif

  assign c_rvalid = rd_pend_q & (owner_q == PORT_C);
  assign d_rvalid = rd_pend_q & (owner_q == PORT_D);
  assign c_rdata  = c_rvalid ? mem_rdata : {DATA_W{1'b0}};
  assign d_rdata  = d_rvalid ? mem_rdata : {DATA_W{1'b0}};

endmodule
